core_pipe_fetch_cfr: RTL and testbench



---
 rtl/core_pipe_fetch_cfr.sv | 147 ++++++++++++++
 tb/tb_core_pipe_fetch_cfr.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_pipe_fetch_cfr.sv
// Instruction fetch stage: issues imem reads, buffers responses for decode and
// responds to control-flow redirects. Optional same-cycle redirect fetch: CORE_FETCH_CF_BYPASS_EN.
module core_pipe_fetch_cfr #(
  parameter int unsigned         MEM_ADDR_R      = 31,
  parameter int unsigned         XL              = 31,
  parameter logic [MEM_ADDR_R:0] PC_RESET        = '0,
  parameter int unsigned         BUF_DEPTH       = 4,
  parameter int unsigned         MAX_OUTSTANDING = 2
) (
  input  logic                  g_clk,
  input  logic                  g_resetn,
  input  logic                  cf_valid,
  output logic                  cf_ack,
  input  logic [MEM_ADDR_R:0]   cf_target,
  output logic                  imem_req,
  input  logic                  imem_gnt,
  output logic [MEM_ADDR_R:0]   imem_addr,
  input  logic                  imem_recv,
  input  logic [31:0]           imem_rdata,
  input  logic                  imem_error,
  output logic                  s1_valid,
  input  logic                  s1_ready,
  output logic [31:0]           s1_instr,
  output logic [XL:0]           s1_pc,
  output logic                  s1_error
);

  localparam int unsigned AW  = MEM_ADDR_R + 1;
  localparam int unsigned PCW = XL + 1;
  localparam int unsigned PW  = $clog2(BUF_DEPTH);
  localparam int unsigned CW  = PW + 2;

  typedef struct packed {
    logic [31:0]   instr;
    logic          err;
    logic [AW-1:0] pc;
  } entry_t;

  logic [AW-1:0] pc_q, pc_d;
  logic          req_hold_q, req_hold_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  entry_t        buf_q [BUF_DEPTH];
  logic [AW-1:0] aq_q  [MAX_OUTSTANDING];

  logic          grant, push, pop, room;
  logic [CW-1:0] aq_idx;
  logic [AW-1:0] grant_pc;
  entry_t        head;

  assign cf_ack = g_resetn && cf_valid && !req_hold_q;
  assign grant  = imem_req && imem_gnt;
  assign pop    = s1_valid && s1_ready;
  assign push   = imem_recv && (disc_q == '0) && !cf_ack;
  assign room   = ((cnt_q + outst_q - disc_q) < CW'(BUF_DEPTH)) &&
                  (outst_q < CW'(MAX_OUTSTANDING));

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = {pc_q[AW-1:2], 2'b00};
    if (!g_resetn) begin
      imem_req = 1'b0;
    end else if (req_hold_q) begin
      imem_req = 1'b1;
    end else if (cf_ack) begin
`ifdef CORE_FETCH_CF_BYPASS_EN
      imem_req  = (outst_q - CW'(imem_recv)) < CW'(MAX_OUTSTANDING);
      imem_addr = {cf_target[AW-1:2], 2'b00};
`else
      imem_req  = 1'b0;
`endif
    end else begin
      imem_req = room;
    end
  end

  // The in-flight PC queue is a shift register: the head always matches the next response.
  assign grant_pc = cf_ack ? cf_target : pc_q;
  assign aq_idx   = outst_q - CW'(imem_recv);

  always_comb begin
    req_hold_d = imem_req && !imem_gnt;
    outst_d    = outst_q + CW'(grant) - CW'(imem_recv);
    pc_d       = pc_q;
    disc_d     = disc_q;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    wp_d       = wp_q + PW'(push);
    rp_d       = rp_q + PW'(pop);
    if (imem_recv && (disc_q != '0)) begin
      disc_d = disc_q - CW'(1);
    end
    if (cf_ack) begin
      pc_d   = grant ? (cf_target + AW'(4)) : cf_target;
      disc_d = outst_d;
      cnt_d  = '0;
      wp_d   = '0;
      rp_d   = '0;
    end else if (grant) begin
      pc_d = pc_q + AW'(4);
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      pc_q       <= PC_RESET;
      req_hold_q <= 1'b0;
      outst_q    <= '0;
      disc_q     <= '0;
      cnt_q      <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
    end else begin
      pc_q       <= pc_d;
      req_hold_q <= req_hold_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
      cnt_q      <= cnt_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
    end
  end

  always_ff @(posedge g_clk) begin
    if (push) begin
      buf_q[wp_q] <= '{instr: imem_rdata, err: imem_error, pc: aq_q[0]};
    end
    if (imem_recv) begin
      for (int unsigned i = 0; i + 1 < MAX_OUTSTANDING; i++) begin
        aq_q[i] <= aq_q[i+1];
      end
    end
    for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
      if (grant && (aq_idx == CW'(i))) begin
        aq_q[i] <= grant_pc;
      end
    end
  end

  assign head     = buf_q[rp_q];
  assign s1_valid = (cnt_q != '0);
  assign s1_instr = head.instr;
  assign s1_error = head.err;
  assign s1_pc    = PCW'(head.pc);

endmodule

// File: tb/tb_core_pipe_fetch_cfr.sv
// Bench for core_pipe_fetch_cfr: in-order memory responder, decode-stream reference
// model, directed redirect table plus randomized traffic.
module tb_core_pipe_fetch_cfr;

  localparam int unsigned MAXO = 2;

  logic        g_clk, g_resetn;
  logic        cf_valid, cf_ack;
  logic [31:0] cf_target;
  logic        imem_req, imem_gnt, imem_recv, imem_error;
  logic [31:0] imem_addr, imem_rdata;
  logic        s1_valid, s1_ready, s1_error;
  logic [31:0] s1_instr, s1_pc;

  core_pipe_fetch_cfr #(
    .MEM_ADDR_R(31), .XL(31), .PC_RESET(32'h1000), .BUF_DEPTH(4), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .cf_valid(cf_valid), .cf_ack(cf_ack), .cf_target(cf_target),
    .imem_req(imem_req), .imem_gnt(imem_gnt), .imem_addr(imem_addr),
    .imem_recv(imem_recv), .imem_rdata(imem_rdata), .imem_error(imem_error),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_instr(s1_instr),
    .s1_pc(s1_pc), .s1_error(s1_error)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } pend_t;

  typedef struct {
    int unsigned delay;
    int unsigned lat;
    logic [31:0] t1;
    logic [31:0] t2;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  pend_t       pending[$];

  logic        nx_resetn = 1'b0, nx_cf_valid = 1'b0, nx_ready = 1'b1;
  logic [31:0] nx_target = '0;
  int unsigned gnt_prob = 100, lat_min = 1, lat_max = 1;
  logic        rand_ready = 1'b0, rand_cf = 1'b0, rand_err = 1'b0, force_gnt0 = 1'b0;
  logic [31:0] err_addr = 32'hFFFF_FFF0;

  logic [31:0] exp_pc = 32'h1000;
  logic        hold_prev = 1'b0, flush_chk = 1'b0;
  logic [31:0] prev_addr = '0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return (a == err_addr) || (rand_err && (a[6:2] == 5'd19));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    logic [31:0] a;
    @(negedge g_clk);
    cyc++;
    g_resetn = nx_resetn;
    if (rand_cf && !nx_cf_valid && ($urandom_range(99) < 6)) begin
      nx_cf_valid = 1'b1;
      nx_target   = 32'h0000_8000 + ($urandom_range(4095) << 2);
    end
    cf_valid  = nx_cf_valid;
    cf_target = nx_target;
    s1_ready  = rand_ready ? ($urandom_range(99) < 70) : nx_ready;
    imem_gnt  = force_gnt0 ? 1'b0 : ($urandom_range(99) < gnt_prob);
    imem_recv = (pending.size() > 0) && (pending[0].due <= cyc);
    if (imem_recv) begin
      a          = pending[0].addr;
      imem_rdata = mem_data(a);
      imem_error = mem_err(a);
    end else begin
      imem_rdata = '0;
      imem_error = 1'b0;
    end
    #1;
    if (g_resetn) begin
      if (hold_prev) begin
        chk("hold_req", imem_req, 1);
        chk("hold_addr", imem_addr, prev_addr);
      end
      chk("cf_ack", cf_ack, cf_valid && !hold_prev);
      if (imem_req) chk("addr_align", imem_addr[1:0], 0);
      if (flush_chk) chk("flush_valid", s1_valid, 0);
      if (s1_valid && s1_ready) begin
        chk("stream_pc", s1_pc, exp_pc);
        chk("stream_instr", s1_instr, mem_data({exp_pc[31:2], 2'b00}));
        chk("stream_err", s1_error, mem_err({exp_pc[31:2], 2'b00}));
        exp_pc = exp_pc + 32'd4;
      end
      if (imem_recv) void'(pending.pop_front());
      if (imem_req && imem_gnt) begin
        pending.push_back('{addr: imem_addr, due: cyc + $urandom_range(lat_max, lat_min)});
        chk("outstanding_max", pending.size() <= MAXO, 1);
      end
      if (cf_ack) begin
        exp_pc = cf_target;
        if (rand_cf) nx_cf_valid = 1'b0;
      end
      flush_chk = cf_ack;
      hold_prev = imem_req && !imem_gnt;
      prev_addr = imem_addr;
    end else begin
      hold_prev = 1'b0;
      flush_chk = 1'b0;
    end
  endtask

  task automatic do_reset(input int unsigned n);
    nx_resetn   = 1'b0;
    nx_cf_valid = 1'b1;
    pending.delete();
    repeat (n) step();
    chk("rst_req", imem_req, 0);
    chk("rst_ack", cf_ack, 0);
    chk("rst_valid", s1_valid, 0);
    nx_resetn   = 1'b1;
    nx_cf_valid = 1'b0;
    exp_pc      = 32'h1000;
  endtask

  task automatic wait_valid(input string name, input int unsigned bound);
    bit found = 0;
    for (int unsigned k = 0; k < bound; k++) begin
      step();
      if (s1_valid) begin found = 1; break; end
    end
    chk(name, found, 1);
  endtask

  vec_t vecs[4];

  initial begin
    logic [31:0] haddr;
    bit found;

    vecs[0] = '{delay: 8, lat: 3, t1: 32'h2000, t2: 32'h0,    exp_pc: 32'h2000, exp_instr: mem_data(32'h2000)};
    vecs[1] = '{delay: 5, lat: 1, t1: 32'h3000, t2: 32'h0,    exp_pc: 32'h3000, exp_instr: mem_data(32'h3000)};
    vecs[2] = '{delay: 6, lat: 2, t1: 32'h5000, t2: 32'h6000, exp_pc: 32'h6000, exp_instr: mem_data(32'h6000)};
    vecs[3] = '{delay: 3, lat: 1, t1: 32'h7004, t2: 32'h0,    exp_pc: 32'h7004, exp_instr: mem_data(32'h7004)};

    g_resetn = 1'b0; cf_valid = 1'b0; cf_target = '0; s1_ready = 1'b0;
    imem_gnt = 1'b0; imem_recv = 1'b0; imem_rdata = '0; imem_error = 1'b0;

    // Reset, first fetch, gap-free stream, error word at 0x1008
    err_addr = 32'h1008;
    do_reset(3);
    step();
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 32'h1000);
    wait_valid("fill_timeout", 10);
    for (int unsigned i = 0; i < 4; i++) begin
      chk("seq_valid", s1_valid, 1);
      chk("seq_pc", s1_pc, 32'h1000 + 4 * i);
      chk("seq_err", s1_error, (i == 2));
      if (i < 3) step();
    end
    err_addr = 32'hFFFF_FFF0;

    // Decode stalled: buffer fills to depth, fetch stops, resumes at 0x1010
    nx_ready = 1'b0;
    do_reset(2);
    repeat (12) step();
    chk("stall_req", imem_req, 0);
    chk("stall_valid", s1_valid, 1);
    chk("stall_head", s1_pc, 32'h1000);
    nx_ready = 1'b1;
    found = 0;
    for (int unsigned k = 0; k < 10; k++) begin
      step();
      if (imem_req) begin found = 1; break; end
    end
    chk("resume_timeout", found, 1);
    chk("resume_addr", imem_addr, 32'h1010);

    // Redirect held off by a pending ungranted request
    repeat (6) step();
    force_gnt0 = 1'b1;
    step();
    chk("hold_setup_req", imem_req, 1);
    haddr = imem_addr;
    nx_cf_valid = 1'b1;
    nx_target   = 32'h4000;
    repeat (2) begin
      step();
      chk("held_ack", cf_ack, 0);
      chk("held_addr", imem_addr, haddr);
    end
    force_gnt0 = 1'b0;
    step();
    chk("grant_cycle_ack", cf_ack, 0);
    chk("grant_cycle_addr", imem_addr, haddr);
    step();
    chk("ack_after_grant", cf_ack, 1);
    nx_cf_valid = 1'b0;
    wait_valid("hold_redirect_timeout", 30);
    chk("hold_redirect_pc", s1_pc, 32'h4000);

    // Redirect table
    for (int unsigned r = 0; r < 4; r++) begin
      lat_min = vecs[r].lat;
      lat_max = vecs[r].lat;
      repeat (vecs[r].delay) step();
      nx_cf_valid = 1'b1;
      nx_target   = vecs[r].t1;
      found = 0;
      for (int unsigned k = 0; k < 10; k++) begin
        step();
        if (cf_ack) begin found = 1; break; end
      end
      chk("vec_ack", found, 1);
`ifdef CORE_FETCH_CF_BYPASS_EN
      if (vecs[r].lat == 1 && vecs[r].t2 == 0) begin
        chk("bypass_req", imem_req, 1);
        chk("bypass_addr", imem_addr, vecs[r].t1);
      end
`endif
      if (vecs[r].t2 != 0) begin
        nx_target = vecs[r].t2;
        step();
        chk("vec_b2b_ack", cf_ack, 1);
      end
      nx_cf_valid = 1'b0;
`ifndef CORE_FETCH_CF_BYPASS_EN
      if (vecs[r].lat == 1 && vecs[r].t2 == 0) begin
        step();
        chk("next_cycle_req", imem_req, 1);
        chk("next_cycle_addr", imem_addr, vecs[r].t1);
      end
`endif
      wait_valid("vec_timeout", 30);
      chk("vec_pc", s1_pc, vecs[r].exp_pc);
      chk("vec_instr", s1_instr, vecs[r].exp_instr);
    end

    // Randomized traffic with a mid-run reset
    gnt_prob = 70; lat_min = 1; lat_max = 4;
    rand_ready = 1'b1; rand_cf = 1'b1; rand_err = 1'b1;
    for (int unsigned c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset(2);
      step();
    end
    chk("random_progress", checks > 3000, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
